// File: rtl/dac_spi_tx.sv
// ============================================================================
// Module   : dac_spi_tx
// Purpose  : Periodic sampler of a 16-bit sine word, shifted MSB-first to an
//            external SPI DAC with CS_N/SCLK/MOSI framing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_spi_tx #(
    parameter int SCLK_DIV      = 2,
    parameter int SAMPLE_PERIOD = 100,
    parameter int SIGN_FLIP     = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [15:0] din,
    input  logic        en,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_mosi,
    output logic        busy,
    output logic        frame_done
);

    localparam int              TW          = $clog2(SAMPLE_PERIOD + 1);
    localparam int              PW          = $clog2(SCLK_DIV + 1);
    localparam logic [TW-1:0]   C_TICK      = TW'(SAMPLE_PERIOD - 1);
    localparam logic [PW-1:0]   C_PHASE_END = PW'(SCLK_DIV - 1);
    localparam logic [15:0]     C_FLIP_MASK = (SIGN_FLIP != 0) ? 16'h8000 : 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   tcnt_q;
    logic [TW-1:0]   tcnt_d;
    logic [PW-1:0]   pcnt_q;
    logic [3:0]      bcnt_q;
    logic [15:0]     sreg_q;
    logic            cs_n_q;
    logic            sclk_q;
    logic            busy_q;
    logic            done_q;
    logic            w_tick;

    // Free-running conversion tick, independent of enable and frame state
    always_comb begin
        w_tick = (tcnt_q == C_TICK);
        tcnt_d = w_tick ? '0 : tcnt_q + TW'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            pcnt_q  <= '0;
            bcnt_q  <= '0;
            sreg_q  <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_tick && en) begin
                        sreg_q  <= din ^ C_FLIP_MASK;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        sclk_q  <= 1'b0;
                        pcnt_q  <= '0;
                        bcnt_q  <= '0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (pcnt_q == C_PHASE_END) begin
                        pcnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            // Zero fill leaves MOSI low once the last bit is out
                            sclk_q <= 1'b0;
                            sreg_q <= {sreg_q[14:0], 1'b0};
                            if (bcnt_q == 4'd15) begin
                                state_q <= S_HOLD;
                            end else begin
                                bcnt_q <= bcnt_q + 4'd1;
                            end
                        end
                    end else begin
                        pcnt_q <= pcnt_q + PW'(1);
                    end
                end
                S_HOLD: begin
                    if (pcnt_q == C_PHASE_END) begin
                        pcnt_q  <= '0;
                        cs_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        pcnt_q <= pcnt_q + PW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_mosi   = sreg_q[15];
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
// ============================================================================
// Module   : tb_dac_spi_tx
// Purpose  : Scoreboard bench for dac_spi_tx (default and sign-flip builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dac_spi_tx;

    localparam int D = 2;
    localparam int P = 100;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        en    = 1'b0;
    logic [15:0] din   = 16'h0000;
    logic [15:0] din_f = 16'h0000;

    logic cs_n, sclk, mosi, busy, done;
    logic f_cs_n, f_sclk, f_mosi, f_busy, f_done;

    always #10 clk = ~clk;

    dac_spi_tx #(.SCLK_DIV(D), .SAMPLE_PERIOD(P), .SIGN_FLIP(0)) u_dut (
        .sys_clk(clk), .sys_rst(rst), .din(din), .en(en),
        .dac_cs_n(cs_n), .dac_sclk(sclk), .dac_mosi(mosi),
        .busy(busy), .frame_done(done)
    );

    dac_spi_tx #(.SCLK_DIV(D), .SAMPLE_PERIOD(P), .SIGN_FLIP(1)) u_flip (
        .sys_clk(clk), .sys_rst(rst), .din(din_f), .en(en),
        .dac_cs_n(f_cs_n), .dac_sclk(f_sclk), .dac_mosi(f_mosi),
        .busy(f_busy), .frame_done(f_done)
    );

    typedef struct {
        logic [15:0] word;
        int          fall;
    } exp_t;

    exp_t        q[$];
    logic [15:0] fq[$];

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic rst_s = 1'b0;

    // cyc at a falling edge is the index of the cycle whose values are visible
    always @(posedge clk) begin
        rst_s <= rst;
        cyc   <= rst ? 0 : cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic wait_cyc(input int c);
        int g;
        g = 0;
        @(negedge clk);
        while (cyc != c && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != c) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_timeout: reached cycle %0d, expected %0d", cyc, c);
        end
    endtask

    // Monitor for the default build: framing, timing and word reconstruction
    logic        pcs = 1'b1, psclk = 1'b0;
    bit          inf = 1'b0;
    int          start = 0, nb = 0;
    logic [15:0] sh = '0;
    exp_t        e;

    always @(negedge clk) begin
        if (rst_s) begin
            chk("rst_cs_n", cs_n, 1);
            chk("rst_sclk", sclk, 0);
            chk("rst_mosi", mosi, 0);
            chk("rst_busy", busy, 0);
            chk("rst_frame_done", done, 0);
            if (inf && q.size() > 0) void'(q.pop_front());
            inf = 1'b0;
        end else begin
            chk("busy_vs_cs_n", busy, !cs_n);
            if (cs_n) begin
                chk("idle_sclk", sclk, 0);
                chk("idle_mosi", mosi, 0);
            end
            if (pcs && !cs_n) begin
                start = cyc;
                nb    = 0;
                sh    = '0;
                inf   = 1'b1;
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_frame at cycle %0d: got cs_n fall, expected none", cyc);
                end else begin
                    chk("cs_fall_cycle", cyc, q[0].fall);
                end
            end
            if (!psclk && sclk) begin
                chk("sclk_rise_cycle", cyc, start + 2*nb*D + D);
                sh = {sh[14:0], mosi};
                nb++;
            end
            if (psclk && !sclk) chk("sclk_fall_cycle", cyc, start + 2*nb*D);
            if (!pcs && cs_n) begin
                chk("frame_done_at_cs_rise", done, 1);
                chk("cs_rise_cycle", cyc, start + 33*D);
                chk("bit_count", nb, 16);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("frame_word", sh, e.word);
                end
                inf = 1'b0;
            end else if (done) begin
                chk("stray_frame_done", done, 0);
            end
        end
        pcs   = cs_n;
        psclk = sclk;
    end

    // Monitor for the sign-flip build: transmitted word only
    logic        fpcs = 1'b1, fpsclk = 1'b0;
    bit          finf = 1'b0;
    int          fnb = 0;
    logic [15:0] fsh = '0;

    always @(negedge clk) begin
        if (rst_s) begin
            if (finf && fq.size() > 0) void'(fq.pop_front());
            finf = 1'b0;
        end else begin
            chk("flip_busy_vs_cs_n", f_busy, !f_cs_n);
            if (fpcs && !f_cs_n) begin
                fsh  = '0;
                fnb  = 0;
                finf = 1'b1;
            end
            if (!fpsclk && f_sclk) begin
                fsh = {fsh[14:0], f_mosi};
                fnb++;
            end
            if (!fpcs && f_cs_n) begin
                finf = 1'b0;
                chk("flip_frame_done", f_done, 1);
                chk("flip_bit_count", fnb, 16);
                if (fq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL flip_unexpected_frame at cycle %0d: got frame %0h, expected none", cyc, fsh);
                end else begin
                    chk("flip_word", fsh, fq.pop_front());
                end
            end
        end
        fpcs   = f_cs_n;
        fpsclk = f_sclk;
    end

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        din   = 16'hA5C3;
        din_f = 16'h0000;
        repeat (5) @(negedge clk);

        q.push_back('{16'hA5C3, 100});
        q.push_back('{16'hA5C3, 200});
        fq.push_back(16'h8000);
        fq.push_back(16'h8000);
        en  = 1'b1;
        rst = 1'b0;

        wait_cyc(250);
        din   = 16'h1234;
        din_f = 16'h7FFF;
        q.push_back('{16'h1234, 300});
        fq.push_back(16'hFFFF);

        wait_cyc(320);
        din = 16'hFFFF;
        q.push_back('{16'hFFFF, 400});
        fq.push_back(16'hFFFF);

        wait_cyc(450);
        en = 1'b0;

        wait_cyc(550);
        en    = 1'b1;
        din   = 16'h5A0F;
        din_f = 16'h1234;
        q.push_back('{16'h5A0F, 600});
        fq.push_back(16'h9234);

        wait_cyc(630);
        en = 1'b0;

        wait_cyc(750);
        en  = 1'b1;
        din = 16'h8001;
        q.push_back('{16'h8001, 800});
        fq.push_back(16'h9234);

        // Reset lands while bit 5 of the frame at 800 is on the wire
        wait_cyc(821);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        q.push_back('{16'h8001, 100});
        fq.push_back(16'h9234);
        rst = 1'b0;

        wait_cyc(180);
        chk("queue_drained", q.size(), 0);
        chk("flip_queue_drained", fq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
